uart_fifo_ctrl: RTL and testbench

Byte-stream controller on the parallel side of the UART PHY.
- Buffers outgoing bytes in a TX FIFO and drives the PHY tx_data/tx_valid/tx_ready handshake.
- Captures the PHY's single-cycle rx_ready pulses into an RX FIFO.
- Exposes data, status and interrupt-enable registers on a simple single-cycle register bus to the SoC interconnect.
- Produces a level interrupt.

---
 rtl/uart_fifo_ctrl.sv | 179 +++++++++++++++++
 tb/tb_uart_fifo_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo_ctrl.sv
// +----------------------------------------------------------------------------+
// | Module      : uart_fifo_ctrl                                                |
// | Description : Parallel-side UART byte controller. TX and RX FIFOs, PHY      |
// |               handshakes, DATA/STATUS/IE register bus and a level irq.      |
// |               Optional macro UART_FIFO_CTRL_LOOPBACK_EN adds IE bit2        |
// |               loopback (TX head moved straight into the RX FIFO).           |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

module uart_fifo_ctrl #(
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bus_en,
  input  logic       bus_we,
  input  logic [1:0] bus_addr,
  input  logic [7:0] bus_wdata,
  output logic [7:0] bus_rdata,
  output logic       bus_rvalid,
  output logic [7:0] phy_tx_data,
  output logic       phy_tx_valid,
  input  logic       phy_tx_ready,
  input  logic [7:0] phy_rx_data,
  input  logic       phy_rx_ready,
  output logic       irq
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
`ifdef UART_FIFO_CTRL_LOOPBACK_EN
  localparam int IE_W = 3;
`else
  localparam int IE_W = 2;
`endif
  localparam logic [CNT_W-1:0] c_FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] c_PTR_ONE  = PTR_W'(1);

  logic [7:0]       r_tx_mem [FIFO_DEPTH];
  logic [7:0]       r_rx_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_tx_wr, r_tx_rd, r_rx_wr, r_rx_rd;
  logic [CNT_W-1:0] r_tx_cnt, r_rx_cnt;
  logic [IE_W-1:0]  r_ie;
  logic             r_ovr;

  // Bus decode
  logic w_rd, w_wr_data, w_rd_data, w_wr_status, w_wr_ie;
  assign w_rd        = bus_en & ~bus_we;
  assign w_wr_data   = bus_en & bus_we & (bus_addr == 2'd0);
  assign w_rd_data   = w_rd & (bus_addr == 2'd0);
  assign w_wr_status = bus_en & bus_we & (bus_addr == 2'd1);
  assign w_wr_ie     = bus_en & bus_we & (bus_addr == 2'd2);

  // FIFO state flags (all evaluated on pre-edge state)
  logic       w_tx_nonempty, w_tx_full, w_tx_empty, w_rx_nonempty, w_rx_full;
  logic [7:0] w_tx_head, w_rx_head;
  assign w_tx_nonempty = (r_tx_cnt != '0);
  assign w_tx_full     = (r_tx_cnt == c_FULL_CNT);
  assign w_tx_empty    = ~w_tx_nonempty & phy_tx_ready;
  assign w_rx_nonempty = (r_rx_cnt != '0);
  assign w_rx_full     = (r_rx_cnt == c_FULL_CNT);
  assign w_tx_head     = r_tx_mem[r_tx_rd];
  assign w_rx_head     = r_rx_mem[r_rx_rd];

  logic       w_tx_push, w_tx_pop, w_rx_pop, w_rx_push, w_rx_in_valid, w_ovr_set;
  logic [7:0] w_rx_in_data;
  assign w_tx_push = w_wr_data & ~w_tx_full;
  assign w_rx_pop  = w_rd_data & w_rx_nonempty;

`ifdef UART_FIFO_CTRL_LOOPBACK_EN
  // Loopback: PHY side is silenced in both directions, TX head feeds RX
  logic w_lb, w_lb_move;
  assign w_lb          = r_ie[2];
  assign w_lb_move     = w_lb & w_tx_nonempty & ~w_rx_full;
  assign phy_tx_valid  = w_tx_nonempty & ~w_lb;
  assign w_tx_pop      = (phy_tx_valid & phy_tx_ready) | w_lb_move;
  assign w_rx_in_valid = w_lb ? w_lb_move : phy_rx_ready;
  assign w_rx_in_data  = w_lb ? w_tx_head : phy_rx_data;
  assign w_ovr_set     = ~w_lb & phy_rx_ready & w_rx_full & ~w_rx_pop;
`else
  assign phy_tx_valid  = w_tx_nonempty;
  assign w_tx_pop      = w_tx_nonempty & phy_tx_ready;
  assign w_rx_in_valid = phy_rx_ready;
  assign w_rx_in_data  = phy_rx_data;
  assign w_ovr_set     = phy_rx_ready & w_rx_full & ~w_rx_pop;
`endif

  // A full RX FIFO still accepts a byte when the bus frees a slot the same cycle
  assign w_rx_push   = w_rx_in_valid & (~w_rx_full | w_rx_pop);
  // Head is masked so the data output is 0 whenever nothing is queued
  assign phy_tx_data = w_tx_nonempty ? w_tx_head : 8'h00;

  logic [7:0] w_status;
  assign w_status = {3'b000, r_ovr, w_tx_empty, w_tx_full, w_rx_full, w_rx_nonempty};

  // Register read multiplexer
  logic [7:0] w_rd_mux;
  always_comb begin
    w_rd_mux = 8'h00;
    case (bus_addr)
      2'd0:    w_rd_mux = w_rx_nonempty ? w_rx_head : 8'h00;
      2'd1:    w_rd_mux = w_status;
      2'd2:    w_rd_mux = {{(8 - IE_W){1'b0}}, r_ie};
      default: w_rd_mux = 8'h00;
    endcase
  end

  // FIFO storage arrays (no reset needed; validity is tracked by the counts)
  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wr] <= bus_wdata;
    if (w_rx_push) r_rx_mem[r_rx_wr] <= w_rx_in_data;
  end

  // TX FIFO pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_wr  <= '0;
      r_tx_rd  <= '0;
      r_tx_cnt <= '0;
    end else begin
      if (w_tx_push) r_tx_wr <= r_tx_wr + c_PTR_ONE;
      if (w_tx_pop)  r_tx_rd <= r_tx_rd + c_PTR_ONE;
      case ({w_tx_push, w_tx_pop})
        2'b10:   r_tx_cnt <= r_tx_cnt + c_CNT_ONE;
        2'b01:   r_tx_cnt <= r_tx_cnt - c_CNT_ONE;
        default: r_tx_cnt <= r_tx_cnt;
      endcase
    end
  end

  // RX FIFO pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_wr  <= '0;
      r_rx_rd  <= '0;
      r_rx_cnt <= '0;
    end else begin
      if (w_rx_push) r_rx_wr <= r_rx_wr + c_PTR_ONE;
      if (w_rx_pop)  r_rx_rd <= r_rx_rd + c_PTR_ONE;
      case ({w_rx_push, w_rx_pop})
        2'b10:   r_rx_cnt <= r_rx_cnt + c_CNT_ONE;
        2'b01:   r_rx_cnt <= r_rx_cnt - c_CNT_ONE;
        default: r_rx_cnt <= r_rx_cnt;
      endcase
    end
  end

  // Control registers: IE and sticky overrun (a new overrun beats a W1C clear)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ie  <= '0;
      r_ovr <= 1'b0;
    end else begin
      if (w_wr_ie) r_ie <= bus_wdata[IE_W-1:0];
      if (w_ovr_set)
        r_ovr <= 1'b1;
      else if (w_wr_status & bus_wdata[4])
        r_ovr <= 1'b0;
    end
  end

  // Registered bus read response and level interrupt
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_rdata  <= 8'h00;
      bus_rvalid <= 1'b0;
      irq        <= 1'b0;
    end else begin
      bus_rvalid <= w_rd;
      if (w_rd) bus_rdata <= w_rd_mux;
      irq <= (r_ie[0] & w_rx_nonempty) | (r_ie[1] & w_tx_empty) | r_ovr;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_fifo_ctrl.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_uart_fifo_ctrl                                             |
// | Description : Directed self-checking bench for uart_fifo_ctrl (default      |
// |               build, FIFO_DEPTH = 16).                                      |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_uart_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       bus_en = 1'b0;
  logic       bus_we = 1'b0;
  logic [1:0] bus_addr = 2'd0;
  logic [7:0] bus_wdata = 8'h00;
  logic [7:0] bus_rdata;
  logic       bus_rvalid;
  logic [7:0] phy_tx_data;
  logic       phy_tx_valid;
  logic       phy_tx_ready = 1'b1;
  logic [7:0] phy_rx_data = 8'h00;
  logic       phy_rx_ready = 1'b0;
  logic       irq;

  int checks = 0;
  int errors = 0;

  uart_fifo_ctrl #(.FIFO_DEPTH(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus_en       (bus_en),
    .bus_we       (bus_we),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_rdata    (bus_rdata),
    .bus_rvalid   (bus_rvalid),
    .phy_tx_data  (phy_tx_data),
    .phy_tx_valid (phy_tx_valid),
    .phy_tx_ready (phy_tx_ready),
    .phy_rx_data  (phy_rx_data),
    .phy_rx_ready (phy_rx_ready),
    .irq          (irq)
  );

  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // All tasks start and end at a falling edge
  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    bus_en = 1'b1; bus_we = 1'b1; bus_addr = a; bus_wdata = d;
    @(negedge clk);
    bus_en = 1'b0; bus_we = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    bus_en = 1'b1; bus_we = 1'b0; bus_addr = a;
    @(negedge clk);
    bus_en = 1'b0;
    check("rvalid", {7'd0, bus_rvalid}, 8'h01);
    d = bus_rdata;
  endtask

  task automatic rx_pulse(input logic [7:0] d);
    phy_rx_ready = 1'b1; phy_rx_data = d;
    @(negedge clk);
    phy_rx_ready = 1'b0;
  endtask

  // PHY accepts the head byte: ready high for exactly one cycle
  task automatic phy_take(input logic [7:0] exp, input string tag);
    check({tag, "_valid"}, {7'd0, phy_tx_valid}, 8'h01);
    check(tag, phy_tx_data, exp);
    phy_tx_ready = 1'b1;
    @(negedge clk);
    phy_tx_ready = 1'b0;
  endtask

  logic [7:0] rd;

  initial begin
    // Power-on reset
    repeat (3) @(negedge clk);
    check("rst_tx_valid", {7'd0, phy_tx_valid}, 8'h00);
    check("rst_irq", {7'd0, irq}, 8'h00);
    check("rst_rvalid", {7'd0, bus_rvalid}, 8'h00);
    check("rst_rdata", bus_rdata, 8'h00);
    rst = 1'b0;
    @(negedge clk);

    // Asynchronous reset in the middle of a queued transfer
    phy_tx_ready = 1'b0;
    bus_write(2'd0, 8'hAA);
    bus_write(2'd0, 8'hBB);
    bus_write(2'd0, 8'hCC);
    check("pre_rst_valid", {7'd0, phy_tx_valid}, 8'h01);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", {7'd0, phy_tx_valid}, 8'h00);
    check("async_rst_data", phy_tx_data, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    phy_tx_ready = 1'b1;
    @(negedge clk);
    bus_read(2'd1, rd);
    check("status_after_rst", rd, 8'h08);
    check("irq_after_rst", {7'd0, irq}, 8'h00);

    // TX ordering
    phy_tx_ready = 1'b0;
    bus_write(2'd0, 8'h55);
    bus_write(2'd0, 8'hA3);
    bus_write(2'd0, 8'h0F);
    bus_read(2'd1, rd);
    check("status_tx_busy", rd, 8'h00);
    phy_take(8'h55, "tx0");
    phy_take(8'hA3, "tx1");
    phy_take(8'h0F, "tx2");
    phy_tx_ready = 1'b1;
    @(negedge clk);
    bus_read(2'd1, rd);
    check("status_tx_done", rd, 8'h08);

    // TX overflow: 18 writes into 16 slots
    phy_tx_ready = 1'b0;
    for (int i = 0; i < 18; i++) bus_write(2'd0, 8'(i));
    bus_read(2'd1, rd);
    check("status_tx_full", rd, 8'h04);
    for (int i = 0; i < 16; i++) phy_take(8'(i), "tx_ovf");
    check("tx_drained_valid", {7'd0, phy_tx_valid}, 8'h00);

    // RX overrun: 17 pulses into 16 slots (phy_tx_ready low so bit3 = 0)
    for (int i = 0; i < 17; i++) rx_pulse(8'h10 + 8'(i));
    bus_read(2'd1, rd);
    check("status_rx_ovr", rd, 8'h13);
    for (int i = 0; i < 16; i++) begin
      bus_read(2'd0, rd);
      check("rx_ovr_data", rd, 8'h10 + 8'(i));
    end
    bus_read(2'd0, rd);
    check("rx_empty_read", rd, 8'h00);
    bus_read(2'd1, rd);
    check("status_rx_empty_ovr", rd, 8'h10);
    bus_write(2'd1, 8'h10);
    bus_read(2'd1, rd);
    check("status_ovr_clr", rd, 8'h00);

    // Full RX FIFO with a bus pop and an rx pulse in the same cycle
    for (int i = 0; i < 16; i++) rx_pulse(8'h60 + 8'(i));
    bus_en = 1'b1; bus_we = 1'b0; bus_addr = 2'd0;
    phy_rx_ready = 1'b1; phy_rx_data = 8'h77;
    @(negedge clk);
    bus_en = 1'b0; phy_rx_ready = 1'b0;
    check("simul_read", bus_rdata, 8'h60);
    bus_read(2'd1, rd);
    check("status_simul", rd, 8'h03);
    for (int i = 1; i < 17; i++) begin
      bus_read(2'd0, rd);
      check("simul_drain", rd, (i == 16) ? 8'h77 : 8'h60 + 8'(i));
    end
    bus_read(2'd1, rd);
    check("status_simul_empty", rd, 8'h00);

    // Interrupts
    bus_write(2'd2, 8'h01);
    check("irq_idle", {7'd0, irq}, 8'h00);
    rx_pulse(8'h41);
    check("irq_not_yet", {7'd0, irq}, 8'h00);
    @(negedge clk);
    check("irq_rx_rise", {7'd0, irq}, 8'h01);
    bus_read(2'd0, rd);
    check("irq_rx_data", rd, 8'h41);
    check("irq_still_high", {7'd0, irq}, 8'h01);
    @(negedge clk);
    check("irq_rx_fall", {7'd0, irq}, 8'h00);
    phy_tx_ready = 1'b1;
    bus_write(2'd2, 8'h02);
    @(negedge clk);
    check("irq_tx_empty", {7'd0, irq}, 8'h01);

    // IE readback, reserved address, read-data hold
    bus_write(2'd2, 8'hFB);
    bus_read(2'd2, rd);
    check("ie_readback", rd, 8'h03);
    bus_write(2'd3, 8'hFF);
    check("rdata_hold", bus_rdata, 8'h03);
    check("rvalid_after_write", {7'd0, bus_rvalid}, 8'h00);
    bus_read(2'd3, rd);
    check("reserved_read", rd, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
